defunnel_ctrl_2_1: RTL and testbench
====================================

Name: defunnel_ctrl_2_1

Overview:
- Sequencing controller that sits directly upstream of the 2:1 defunnel datapath.
- Accepts a valid/ready stream of 128-bit beats plus a per-word config byte.
- Drives the datapath's per-lane enable strobes and mode byte so that one or two beats are captured into the 256-bit output word.
- Presents a registered valid/ready handshake for the assembled word to the downstream consumer.

Parameters:
- CFG_W, 8, width of config / mode byte
- EN_W, 8, width of lane enable vector (only bits [1:0] active)
- LANES, 2, lanes per output word (fixed at 2; other values unsupported)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- t_0_valid  in  1  upstream beat valid
- t_0_ready  out  1  upstream beat ready
- t_cfg_dat  in  CFG_W  per-word config; bit0: 0 = gather (2 beats/word), 1 = single (1 beat/word, both lanes)
- enable  out  EN_W  lane capture strobes to datapath
- mode  out  CFG_W  config presented to datapath
- i_0_valid  out  1  assembled word valid
- i_0_ready  in  1  downstream accepts word
- lane_cnt  out  1  index of next lane to fill (status)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low (reset_n); all state updates on posedge clk.
- While reset_n = 0:
  - i_0_valid, lane_cnt, cfg_q all register to 0.
  - t_0_ready and enable are forced to 0 combinationally.
  - mode = 0.
- Handshake: acc = t_0_valid & t_0_ready.
- t_0_ready = reset_n & (~i_0_valid | i_0_ready).
  - Upstream stalls only while an unaccepted word is pending.
  - Zero-bubble: a new final beat may be accepted in the same cycle the old word is taken.
- Mode / config:
  - When lane_cnt = 0: mode = t_cfg_dat (combinational).
  - Otherwise: mode = cfg_q.
  - On acc with lane_cnt = 0: cfg_q <= t_cfg_dat.
  - Config is frozen for the rest of the word; t_cfg_dat changes mid-word are ignored.
- State machine on lane_cnt:
  - FILL0 (0):
    - acc & mode[0] = 1: enable[1:0] = 2'b11; word complete; stay FILL0.
    - acc & mode[0] = 0: enable[0] = 1; go FILL1.
  - FILL1 (1):
    - acc: enable[1] = 1; word complete; go FILL0.
- enable[EN_W-1:2] are always 0. enable is combinational, asserted only in the acc cycle, so the datapath captures on the same edge.
- Output valid:
  - On word complete: i_0_valid <= 1. Data is visible one cycle after the final beat is accepted, matching datapath flop latency.
  - Else if i_0_ready: i_0_valid <= 0.
  - Completion has priority over clear when both happen in the same cycle (back-to-back words keep valid high).
- Ordering: lane 0 always holds the earlier beat. The lane-0 data of a pending word is never overwritten, because t_0_ready is low while i_0_valid & ~i_0_ready.
  - In FILL1 with a word pending, lane 0 of the new word was captured earlier. This is allowed only because the pending word was accepted before that capture: FILL0 acceptance required t_0_ready.
- Throughput: 1 word/cycle in single mode; 1 word/2 cycles in gather mode.
- Reset mid-word: partial word is discarded, lane_cnt returns to 0, and no enable fires during reset.

Optional Feature:
- Macro: DEFUNNEL_CTRL_FLUSH_EN
- Defined:
  - Adds input flush (1 bit) and output i_0_partial (1 bit).
  - flush while lane_cnt = 1 and no acc that cycle:
    - Completes the word with lane 1 not written (enable[1] stays 0).
    - Sets i_0_valid and i_0_partial = 1; lane_cnt returns to 0.
    - Subject to the same pending-word rule as a beat: honoured only when t_0_ready = 1.
  - i_0_partial clears when the word is accepted.
  - flush in FILL0, or coincident with acc, is ignored.
- Undefined: no flush/i_0_partial ports; a partial word waits indefinitely for its second beat.

Test Plan:
- Reset hold:
  - Stimulus: reset_n = 0 for 3 cycles with t_0_valid = 1.
  - Required response: enable = 0, t_0_ready = 0, i_0_valid = 0, lane_cnt = 0; after release, first acc fires enable = 8'h01 (cfg bit0 = 0).
- Gather stream:
  - Stimulus: cfg = 8'h00; beats A, B with i_0_ready = 1.
  - Required response: enable = 8'h01 then 8'h02 on consecutive cycles; i_0_valid high exactly 1 cycle, the cycle after B.
- Single stream:
  - Stimulus: cfg = 8'h01; 4 consecutive beats; i_0_ready = 1.
  - Required response: enable = 8'h03 every cycle; i_0_valid high 4 consecutive cycles starting 1 cycle after first acc.
- Backpressure:
  - Stimulus: gather mode, i_0_ready = 0 for 5 cycles after a word completes.
  - Required response: t_0_ready = 0 and enable = 0 throughout, i_0_valid held 1; when i_0_ready rises, t_0_ready = 1 the same cycle.
- Config freeze:
  - Stimulus: cfg = 8'h00 at beat 0, cfg switched to 8'h01 before beat 1.
  - Required response: beat 1 still gives enable = 8'h02 and mode = 8'h00.
- Flush (macro on):
  - Stimulus: gather mode, one beat, then flush = 1.
  - Required response: i_0_valid = 1 and i_0_partial = 1 next cycle, no enable[1]; next beat gets enable = 8'h01.

Source files
------------

// File: rtl/defunnel_ctrl_2_1.sv
// Sequencing controller for the 2:1 defunnel datapath. It gathers one or two 128-bit beats into a 256-bit word.
// Optional flush of a half-filled word is built when DEFUNNEL_CTRL_FLUSH_EN is defined.
module defunnel_ctrl_2_1 #(
    parameter int CFG_W = 8,
    parameter int EN_W  = 8,
    parameter int LANES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       t_0_valid,
    output logic                       t_0_ready,
    input  logic [CFG_W-1:0]           t_cfg_dat,
    output logic [EN_W-1:0]            enable,
    output logic [CFG_W-1:0]           mode,
    output logic                       i_0_valid,
    input  logic                       i_0_ready,
`ifdef DEFUNNEL_CTRL_FLUSH_EN
    input  logic                       flush,
    output logic                       i_0_partial,
`endif
    output logic [$clog2(LANES)-1:0]   lane_cnt
);

    typedef enum logic {
        FILL0 = 1'b0,
        FILL1 = 1'b1
    } state_t;

    state_t           state_reg;
    logic [CFG_W-1:0] cfg_reg;
    logic             i_0_valid_reg;
    logic             acc;
    logic             word_done;
    logic             flush_done;
    logic [1:0]       lane_en;

`ifdef DEFUNNEL_CTRL_FLUSH_EN
    logic             partial_reg;
`endif

    // Upstream only stalls while an assembled word is still waiting downstream.
    assign t_0_ready = reset_n & (~i_0_valid_reg | i_0_ready);
    assign acc       = t_0_valid & t_0_ready;
    assign i_0_valid = i_0_valid_reg;
    assign lane_cnt  = state_reg;

    always_comb begin
        mode = '0;
        if (reset_n) begin
            mode = (state_reg == FILL0) ? t_cfg_dat : cfg_reg;
        end
    end

    always_comb begin
        lane_en = 2'b00;
        if (acc) begin
            if (state_reg == FILL0) begin
                lane_en = mode[0] ? 2'b11 : 2'b01;
            end else begin
                lane_en = 2'b10;
            end
        end
    end

    assign word_done = acc & ((state_reg == FILL1) | mode[0]);

`ifdef DEFUNNEL_CTRL_FLUSH_EN
    // A flush closes the half word without writing lane 1. It obeys the same pending-word stall as a beat.
    assign flush_done  = flush & (state_reg == FILL1) & ~acc & t_0_ready;
    assign i_0_partial = partial_reg;
`else
    assign flush_done  = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < EN_W; gi = gi + 1) begin : g_enable
            if (gi < 2) begin : g_lane
                assign enable[gi] = lane_en[gi];
            end else begin : g_unused
                assign enable[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= FILL0;
            cfg_reg       <= '0;
            i_0_valid_reg <= 1'b0;
        end else begin
            if (acc && state_reg == FILL0) begin
                cfg_reg <= t_cfg_dat;
            end

            case (state_reg)
                FILL0: if (acc && !mode[0]) state_reg <= FILL1;
                FILL1: if (acc || flush_done) state_reg <= FILL0;
                default: state_reg <= FILL0;
            endcase

            // When a word completes in the same cycle the old one leaves, valid stays high.
            if (word_done || flush_done) begin
                i_0_valid_reg <= 1'b1;
            end else if (i_0_ready) begin
                i_0_valid_reg <= 1'b0;
            end
        end
    end

`ifdef DEFUNNEL_CTRL_FLUSH_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            partial_reg <= 1'b0;
        end else if (flush_done) begin
            partial_reg <= 1'b1;
        end else if (word_done || (i_0_valid_reg && i_0_ready)) begin
            partial_reg <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_defunnel_ctrl_2_1.sv
// Directed self-checking bench for defunnel_ctrl_2_1. Inputs are driven on negedge and outputs are checked 1 ns later.
module tb_defunnel_ctrl_2_1;

    logic       clk;
    logic       reset_n;
    logic       t_0_valid;
    logic       t_0_ready;
    logic [7:0] t_cfg_dat;
    logic [7:0] enable;
    logic [7:0] mode;
    logic       i_0_valid;
    logic       i_0_ready;
    logic [0:0] lane_cnt;
`ifdef DEFUNNEL_CTRL_FLUSH_EN
    logic       flush;
    logic       i_0_partial;
`endif

    int total = 0;
    int bad   = 0;

    defunnel_ctrl_2_1 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .t_0_valid (t_0_valid),
        .t_0_ready (t_0_ready),
        .t_cfg_dat (t_cfg_dat),
        .enable    (enable),
        .mode      (mode),
        .i_0_valid (i_0_valid),
        .i_0_ready (i_0_ready),
`ifdef DEFUNNEL_CTRL_FLUSH_EN
        .flush       (flush),
        .i_0_partial (i_0_partial),
`endif
        .lane_cnt  (lane_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset;
        reset_n = 1'b0; t_0_valid = 1'b1; t_cfg_dat = 8'h00; i_0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if (enable !== 8'h00) begin bad++; $display("FAIL reset_enable got=%h exp=00", enable); end
            total++; if (t_0_ready !== 1'b0) begin bad++; $display("FAIL reset_t0ready got=%b exp=0", t_0_ready); end
            total++; if (i_0_valid !== 1'b0) begin bad++; $display("FAIL reset_ivalid got=%b exp=0", i_0_valid); end
            total++; if (lane_cnt !== 1'b0) begin bad++; $display("FAIL reset_lanecnt got=%b exp=0", lane_cnt); end
        end
        @(negedge clk); reset_n = 1'b1; #1;
        total++; if (enable !== 8'h01) begin bad++; $display("FAIL release_enable got=%h exp=01", enable); end
        total++; if (t_0_ready !== 1'b1) begin bad++; $display("FAIL release_t0ready got=%b exp=1", t_0_ready); end
        @(negedge clk); #1;
        total++; if (lane_cnt !== 1'b1) begin bad++; $display("FAIL release_lanecnt got=%b exp=1", lane_cnt); end
        total++; if (enable !== 8'h02) begin bad++; $display("FAIL release_enable2 got=%h exp=02", enable); end
        @(negedge clk); t_0_valid = 1'b0; #1;
        total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL release_ivalid got=%b exp=1", i_0_valid); end
        @(negedge clk); #1;
        total++; if (i_0_valid !== 1'b0) begin bad++; $display("FAIL release_ivalid_clr got=%b exp=0", i_0_valid); end
        $display("reset hold: released, first word gathered");
    endtask

    task automatic test_gather;
        t_cfg_dat = 8'h00; i_0_ready = 1'b1;
        @(negedge clk); t_0_valid = 1'b1; #1;
        total++; if (enable !== 8'h01) begin bad++; $display("FAIL gather_enA got=%h exp=01", enable); end
        total++; if (i_0_valid !== 1'b0) begin bad++; $display("FAIL gather_validA got=%b exp=0", i_0_valid); end
        @(negedge clk); #1;
        total++; if (enable !== 8'h02) begin bad++; $display("FAIL gather_enB got=%h exp=02", enable); end
        total++; if (lane_cnt !== 1'b1) begin bad++; $display("FAIL gather_lane got=%b exp=1", lane_cnt); end
        total++; if (i_0_valid !== 1'b0) begin bad++; $display("FAIL gather_validB got=%b exp=0", i_0_valid); end
        @(negedge clk); t_0_valid = 1'b0; #1;
        total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL gather_valid got=%b exp=1", i_0_valid); end
        total++; if (enable !== 8'h00) begin bad++; $display("FAIL gather_idle_en got=%h exp=00", enable); end
        @(negedge clk); #1;
        total++; if (i_0_valid !== 1'b0) begin bad++; $display("FAIL gather_valid_clr got=%b exp=0", i_0_valid); end
        $display("gather word: beats A,B captured into lanes 0,1");
    endtask

    task automatic test_single;
        t_cfg_dat = 8'h01; i_0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); t_0_valid = 1'b1; #1;
            total++; if (enable !== 8'h03) begin bad++; $display("FAIL single_en[%0d] got=%h exp=03", i, enable); end
            total++; if (lane_cnt !== 1'b0) begin bad++; $display("FAIL single_lane[%0d] got=%b exp=0", i, lane_cnt); end
            total++; if (i_0_valid !== (i > 0)) begin bad++; $display("FAIL single_valid[%0d] got=%b exp=%b", i, i_0_valid, (i > 0)); end
        end
        @(negedge clk); t_0_valid = 1'b0; #1;
        total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL single_valid_last got=%b exp=1", i_0_valid); end
        @(negedge clk); #1;
        total++; if (i_0_valid !== 1'b0) begin bad++; $display("FAIL single_valid_clr got=%b exp=0", i_0_valid); end
        $display("single words: 4 words at one per cycle");
    endtask

    task automatic test_backpressure;
        t_cfg_dat = 8'h00;
        @(negedge clk); t_0_valid = 1'b1; i_0_ready = 1'b0; #1;
        total++; if (enable !== 8'h01) begin bad++; $display("FAIL bp_enA got=%h exp=01", enable); end
        @(negedge clk); #1;
        total++; if (enable !== 8'h02) begin bad++; $display("FAIL bp_enB got=%h exp=02", enable); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            total++; if (t_0_ready !== 1'b0) begin bad++; $display("FAIL bp_t0ready[%0d] got=%b exp=0", i, t_0_ready); end
            total++; if (enable !== 8'h00) begin bad++; $display("FAIL bp_en[%0d] got=%h exp=00", i, enable); end
            total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, i_0_valid); end
            total++; if (lane_cnt !== 1'b0) begin bad++; $display("FAIL bp_lane[%0d] got=%b exp=0", i, lane_cnt); end
        end
        @(negedge clk); i_0_ready = 1'b1; #1;
        total++; if (t_0_ready !== 1'b1) begin bad++; $display("FAIL bp_release_t0ready got=%b exp=1", t_0_ready); end
        total++; if (enable !== 8'h01) begin bad++; $display("FAIL bp_release_en got=%h exp=01", enable); end
        @(negedge clk); #1;
        total++; if (i_0_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b exp=0", i_0_valid); end
        total++; if (enable !== 8'h02) begin bad++; $display("FAIL bp_next_enB got=%h exp=02", enable); end
        @(negedge clk); t_0_valid = 1'b0; #1;
        total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b exp=1", i_0_valid); end
        @(negedge clk); #1;
        $display("backpressure: word held 5 cycles, then zero-bubble resume");
    endtask

    task automatic test_cfg_freeze;
        i_0_ready = 1'b1;
        @(negedge clk); t_cfg_dat = 8'hA5; #1;
        total++; if (mode !== 8'hA5) begin bad++; $display("FAIL idle_mode got=%h exp=a5", mode); end
        @(negedge clk); t_cfg_dat = 8'h00; t_0_valid = 1'b1; #1;
        total++; if (enable !== 8'h01) begin bad++; $display("FAIL freeze_enA got=%h exp=01", enable); end
        total++; if (mode !== 8'h00) begin bad++; $display("FAIL freeze_modeA got=%h exp=00", mode); end
        @(negedge clk); t_cfg_dat = 8'h01; #1;
        total++; if (enable !== 8'h02) begin bad++; $display("FAIL freeze_enB got=%h exp=02", enable); end
        total++; if (mode !== 8'h00) begin bad++; $display("FAIL freeze_modeB got=%h exp=00", mode); end
        @(negedge clk); t_0_valid = 1'b0; t_cfg_dat = 8'h00; #1;
        total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL freeze_valid got=%b exp=1", i_0_valid); end
        @(negedge clk); #1;
        $display("config freeze: mid-word cfg change ignored");
    endtask

    task automatic test_back_to_back;
        t_cfg_dat = 8'h00; i_0_ready = 1'b1;
        @(negedge clk); t_0_valid = 1'b1; #1;
        total++; if (enable !== 8'h01) begin bad++; $display("FAIL b2b_en0 got=%h exp=01", enable); end
        @(negedge clk); #1;
        total++; if (enable !== 8'h02) begin bad++; $display("FAIL b2b_en1 got=%h exp=02", enable); end
        @(negedge clk); t_cfg_dat = 8'h01; #1;
        total++; if (enable !== 8'h03) begin bad++; $display("FAIL b2b_en2 got=%h exp=03", enable); end
        total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid2 got=%b exp=1", i_0_valid); end
        @(negedge clk); t_0_valid = 1'b0; #1;
        total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid3 got=%b exp=1", i_0_valid); end
        @(negedge clk); #1;
        total++; if (i_0_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_clr got=%b exp=0", i_0_valid); end
        $display("back to back: gather word then single word, valid held high");
    endtask

    task automatic test_reset_midword;
        t_cfg_dat = 8'h00; i_0_ready = 1'b1;
        @(negedge clk); t_0_valid = 1'b1; #1;
        total++; if (enable !== 8'h01) begin bad++; $display("FAIL midrst_enA got=%h exp=01", enable); end
        @(negedge clk); reset_n = 1'b0; #1;
        total++; if (enable !== 8'h00) begin bad++; $display("FAIL midrst_en got=%h exp=00", enable); end
        total++; if (mode !== 8'h00) begin bad++; $display("FAIL midrst_mode got=%h exp=00", mode); end
        @(negedge clk); reset_n = 1'b1; t_cfg_dat = 8'h01; #1;
        total++; if (lane_cnt !== 1'b0) begin bad++; $display("FAIL midrst_lane got=%b exp=0", lane_cnt); end
        total++; if (enable !== 8'h03) begin bad++; $display("FAIL midrst_en_after got=%h exp=03", enable); end
        @(negedge clk); t_0_valid = 1'b0; #1;
        total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL midrst_valid got=%b exp=1", i_0_valid); end
        @(negedge clk); #1;
        $display("reset mid-word: partial word discarded");
    endtask

`ifdef DEFUNNEL_CTRL_FLUSH_EN
    task automatic test_flush;
        t_cfg_dat = 8'h00; i_0_ready = 1'b1; flush = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); flush = 1'b0; #1;
        total++; if (i_0_valid !== 1'b0) begin bad++; $display("FAIL flush_fill0_valid got=%b exp=0", i_0_valid); end
        @(negedge clk); t_0_valid = 1'b1; #1;
        total++; if (enable !== 8'h01) begin bad++; $display("FAIL flush_enA got=%h exp=01", enable); end
        @(negedge clk); t_0_valid = 1'b0; flush = 1'b1; #1;
        total++; if (enable !== 8'h00) begin bad++; $display("FAIL flush_en got=%h exp=00", enable); end
        @(negedge clk); flush = 1'b0; #1;
        total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL flush_valid got=%b exp=1", i_0_valid); end
        total++; if (i_0_partial !== 1'b1) begin bad++; $display("FAIL flush_partial got=%b exp=1", i_0_partial); end
        total++; if (lane_cnt !== 1'b0) begin bad++; $display("FAIL flush_lane got=%b exp=0", lane_cnt); end
        @(negedge clk); t_0_valid = 1'b1; #1;
        total++; if (enable !== 8'h01) begin bad++; $display("FAIL flush_next_en got=%h exp=01", enable); end
        total++; if (i_0_partial !== 1'b0) begin bad++; $display("FAIL flush_partial_clr got=%b exp=0", i_0_partial); end
        @(negedge clk); #1;
        total++; if (enable !== 8'h02) begin bad++; $display("FAIL flush_next_enB got=%h exp=02", enable); end
        @(negedge clk); t_0_valid = 1'b0; #1;
        total++; if (i_0_valid !== 1'b1) begin bad++; $display("FAIL flush_full_valid got=%b exp=1", i_0_valid); end
        total++; if (i_0_partial !== 1'b0) begin bad++; $display("FAIL flush_full_partial got=%b exp=0", i_0_partial); end
        @(negedge clk); #1;
        $display("flush: half word closed as partial, next word full");
    endtask
`endif

    initial begin
        reset_n = 1'b0; t_0_valid = 1'b0; t_cfg_dat = 8'h00; i_0_ready = 1'b1;
`ifdef DEFUNNEL_CTRL_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset();
        test_gather();
        test_single();
        test_backpressure();
        test_cfg_freeze();
        test_back_to_back();
        test_reset_midword();
`ifdef DEFUNNEL_CTRL_FLUSH_EN
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
